// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the data_path. Fetches an
// instruction (T0..T3), then executes register-register ALU operations
// (T4..T7) by driving the bus-drive and register-load strobes.
// Build option: define STEP_MODE_EN to add a `step` input and an IDLE state
// that gates the start of every fetch. Left undefined, there is no IDLE state.
//
// state  | meaning
// -------+----------------------------------------------------------------
// T0     | PC onto bus, load MAR, start PC increment into Zlow
// T1     | incremented PC from Zlow back into PC
// T2     | memory read; held until mem_ready
// T3     | MDR onto bus into IR; opcode decoded on the way out
// T4     | Rb onto bus into Y
// T5     | Rc onto bus, ALU op, result into Z (low and high)
// T6     | Zlow into Ra (single-result) or into LO (MUL/DIV)
// T7     | Zhigh into HI (MUL/DIV only)
// HALTED | everything quiet, Run low, left only through clear
// IDLE   | (STEP_MODE_EN) waiting for step before the next fetch
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             clear,
`ifdef STEP_MODE_EN
  input  logic             step,
`endif
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             ZHighin,
  output logic             HIin,
  output logic             LOin,
  output logic [OPW-1:0]   op,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Run,
  output logic             illegal
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALTED
`ifdef STEP_MODE_EN
    , IDLE
`endif
  } state_t;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out;
    logic mar_in, inc_pc, pc_in, read, mdr_in, ir_in;
    logic y_in, zlow_in, zhigh_in, hi_in, lo_in;
  } strb_t;

  localparam strb_t STRB_FETCH = '{pc_out: 1'b1, mar_in: 1'b1, inc_pc: 1'b1,
                                   zlow_in: 1'b1, default: 1'b0};
`ifdef STEP_MODE_EN
  localparam state_t RESET_ST   = IDLE;
  localparam strb_t  STRB_RESET = '0;
`else
  localparam state_t RESET_ST   = T0;
  localparam strb_t  STRB_RESET = STRB_FETCH;
`endif

  state_t             state, nxt, fetch_st;
  strb_t              strb_q, strb_d;
  logic [NREGS-1:0]   rin_q, rin_d, rout_q, rout_d;
  logic [OPW-1:0]     op_q, op_d;
  logic               illegal_q, run_q;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       is_single, is_dual, is_nop, is_halt, is_illegal;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_single  = (opc <= 5'd5);
  assign is_dual    = (opc == 5'd8) || (opc == 5'd9);
  assign is_nop     = (opc == 5'd30);
  assign is_halt    = (opc == 5'd31);
  assign is_illegal = !(is_single || is_dual || is_nop || is_halt);

`ifdef STEP_MODE_EN
  assign fetch_st = step ? T0 : IDLE;
`else
  assign fetch_st = T0;
`endif

  // Register index to one-hot select; indices beyond NREGS select nothing.
  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  // Next-state: fetch sequence, memory wait in T2, opcode dispatch out of T3.
  always_comb begin
    nxt = state;
    case (state)
      T0:     nxt = T1;
      T1:     nxt = T2;
      T2:     if (mem_ready) nxt = T3;
      T3: begin
        if (is_halt)                  nxt = HALTED;
        else if (is_nop || is_illegal) nxt = fetch_st;
        else                          nxt = T4;
      end
      T4:     nxt = T5;
      T5:     nxt = T6;
      T6:     nxt = is_dual ? T7 : fetch_st;
      T7:     nxt = fetch_st;
      HALTED: nxt = HALTED;
`ifdef STEP_MODE_EN
      IDLE:   if (step) nxt = T0;
`endif
      default: nxt = RESET_ST;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs line up with it.
  always_comb begin
    strb_d = '0;
    rin_d  = '0;
    rout_d = '0;
    op_d   = '0;
    case (nxt)
      T0: strb_d = STRB_FETCH;
      T1: begin strb_d.zlow_out = 1'b1; strb_d.pc_in = 1'b1; end
      T2: begin strb_d.read = 1'b1; strb_d.mdr_in = 1'b1; end
      T3: begin strb_d.mdr_out = 1'b1; strb_d.ir_in = 1'b1; end
      T4: begin rout_d = onehot(rb); strb_d.y_in = 1'b1; end
      T5: begin
        rout_d          = onehot(rc);
        op_d            = OPW'(opc);
        strb_d.zlow_in  = 1'b1;
        strb_d.zhigh_in = 1'b1;
      end
      T6: begin
        strb_d.zlow_out = 1'b1;
        if (is_dual) strb_d.lo_in = 1'b1;
        else         rin_d = onehot(ra);
      end
      T7: begin strb_d.zhigh_out = 1'b1; strb_d.hi_in = 1'b1; end
      default: ;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= RESET_ST;
      strb_q    <= STRB_RESET;
      rin_q     <= '0;
      rout_q    <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      run_q     <= 1'b1;
    end else begin
      state     <= nxt;
      strb_q    <= strb_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      op_q      <= op_d;
      illegal_q <= (state == T3) && is_illegal;
      run_q     <= (nxt != HALTED);
    end
  end

  // The strobe register resets to the T0 pattern so T0 shows the moment clear
  // lifts; gating with clear keeps every strobe low while reset is held.
  assign {PCout, Zlowout, Zhighout, MDRout, MARin, IncPC, PCin, Read, MDRin,
          IRin, Yin, Zlowin, ZHighin, HIin, LOin} = strb_q & {$bits(strb_t){clear}};
  assign Rin     = rin_q;
  assign Rout    = rout_q;
  assign op      = op_q;
  assign illegal = illegal_q;
  assign Run     = run_q;

endmodule
